melody_sequencer: RTL and testbench

- Programmable note sequencer. It sits directly upstream of the square-wave tone generator stage.
- Holds a small writable note table of half-period and duration entries and steps through it on a time-unit tick.
- Drives the tone generator with the current half-period count and a tone-enable flag.
- Replaces hardcoded melody tables: software or a loader writes the table, then pulses start.

---
 rtl/melody_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// melody_sequencer: programmable note sequencer feeding the square-wave
// tone generator. A writable table of {half-period, duration, last} entries
// is stepped through on a TICK_DIV-clock time unit.
// Optional macro SEQ_GAP_EN inserts a GAP_CYCLES-long silent gap between
// consecutive notes (including the loop wrap back to entry 0).
module melody_sequencer #(
  parameter int DEPTH      = 16,
  parameter int PERIOD_W   = 21,
  parameter int DUR_W      = 4,
  parameter int TICK_DIV   = 12_500_000,
  parameter int GAP_CYCLES = 1_250_000
) (
  input  logic                     iCLK,
  input  logic                     iRST_N,
  input  logic                     iWR_EN,
  input  logic [$clog2(DEPTH)-1:0] iWR_ADDR,
  input  logic [PERIOD_W-1:0]      iWR_PERIOD,
  input  logic [DUR_W-1:0]         iWR_DUR,
  input  logic                     iWR_LAST,
  input  logic                     iSTART,
  input  logic                     iSTOP,
  input  logic                     iLOOP,
  output logic [PERIOD_W-1:0]      oHALF_PERIOD,
  output logic                     oTONE_EN,
  output logic [$clog2(DEPTH)-1:0] oNOTE_IDX,
  output logic                     oBUSY,
  output logic                     oDONE
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // note table (not reset; contents undefined until written)
  logic [PERIOD_W-1:0] r_tab_period [DEPTH];
  logic [DUR_W-1:0]    r_tab_dur    [DEPTH];
  logic                r_tab_last   [DEPTH];

  state_t              r_state, w_state_nxt;
  logic [TICK_W-1:0]   r_tick,  w_tick_nxt;
  logic [DUR_W:0]      r_dur,   w_dur_nxt;
  logic [IDX_W-1:0]    r_idx,   w_idx_nxt;
  logic [PERIOD_W-1:0] r_half,  w_half_nxt;
  logic                r_tone,  w_tone_nxt;
  logic                r_done,  w_done_nxt;

`ifdef SEQ_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);
  logic [GAP_W-1:0]    r_gap, w_gap_nxt;
`endif

  // Entry-0 period as seen by a start in the same cycle as a write to it:
  // the fresh write data wins so playback uses the new value.
  logic [PERIOD_W-1:0] w_p0;
  logic [DUR_W-1:0]    w_cur_dur;
  logic [DUR_W:0]      w_eff_dur;
  logic [DUR_W:0]      w_dur_inc;
  logic                w_tick_wrap;
  logic                w_note_end;
  logic                w_is_last;
  logic [IDX_W-1:0]    w_idx_inc;
  logic [IDX_W-1:0]    w_nidx;
  logic [PERIOD_W-1:0] w_nper;

  assign w_p0        = (iWR_EN && (iWR_ADDR == '0)) ? iWR_PERIOD : r_tab_period[0];
  assign w_cur_dur   = r_tab_dur[r_idx];
  assign w_eff_dur   = (w_cur_dur == '0) ? (DUR_W+1)'(1) : {1'b0, w_cur_dur};
  assign w_dur_inc   = r_dur + 1'b1;
  assign w_tick_wrap = (r_tick == TICK_MAX);
  assign w_note_end  = w_tick_wrap && (w_dur_inc >= w_eff_dur);
  assign w_is_last   = r_tab_last[r_idx] || (r_idx == IDX_MAX);
  assign w_idx_inc   = r_idx + 1'b1;
  assign w_nidx      = w_is_last ? '0 : w_idx_inc;
  assign w_nper      = r_tab_period[w_nidx];

  // table write port; only open while idle so playback never sees a change
  always_ff @(posedge iCLK) begin
    if (r_state == S_IDLE && iWR_EN) begin
      r_tab_period[iWR_ADDR] <= iWR_PERIOD;
      r_tab_dur[iWR_ADDR]    <= iWR_DUR;
      r_tab_last[iWR_ADDR]   <= iWR_LAST;
    end
  end

  // next-state, counters and registered output values
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_dur_nxt   = r_dur;
    w_idx_nxt   = r_idx;
    w_half_nxt  = r_half;
    w_tone_nxt  = r_tone;
    w_done_nxt  = 1'b0;
`ifdef SEQ_GAP_EN
    w_gap_nxt   = r_gap;
`endif
    case (r_state)
      S_IDLE: begin
        if (iSTART && !iSTOP) begin
          w_state_nxt = S_PLAY;
          w_tick_nxt  = '0;
          w_dur_nxt   = '0;
          w_idx_nxt   = '0;
          w_half_nxt  = w_p0;
          w_tone_nxt  = (w_p0 != '0);
        end
      end
      S_PLAY: begin
        if (iSTOP) begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = '0;
          w_dur_nxt   = '0;
          w_idx_nxt   = '0;
          w_half_nxt  = '0;
          w_tone_nxt  = 1'b0;
        end else if (w_note_end) begin
          w_tick_nxt = '0;
          w_dur_nxt  = '0;
          if (w_is_last && !iLOOP) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_half_nxt  = '0;
            w_tone_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = w_nidx;
`ifdef SEQ_GAP_EN
            w_state_nxt = S_GAP;
            w_gap_nxt   = '0;
            w_half_nxt  = '0;
            w_tone_nxt  = 1'b0;
`else
            w_half_nxt  = w_nper;
            w_tone_nxt  = (w_nper != '0);
`endif
          end
        end else if (w_tick_wrap) begin
          w_tick_nxt = '0;
          w_dur_nxt  = w_dur_inc;
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
`ifdef SEQ_GAP_EN
      S_GAP: begin
        if (iSTOP) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
          w_half_nxt  = '0;
          w_tone_nxt  = 1'b0;
        end else if (r_gap == GAP_MAX) begin
          // index already points at the upcoming entry
          w_state_nxt = S_PLAY;
          w_tick_nxt  = '0;
          w_dur_nxt   = '0;
          w_half_nxt  = r_tab_period[r_idx];
          w_tone_nxt  = (r_tab_period[r_idx] != '0);
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
        w_half_nxt  = '0;
        w_tone_nxt  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
      r_tick  <= '0;
      r_dur   <= '0;
      r_idx   <= '0;
      r_half  <= '0;
      r_tone  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SEQ_GAP_EN
      r_gap   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_dur   <= w_dur_nxt;
      r_idx   <= w_idx_nxt;
      r_half  <= w_half_nxt;
      r_tone  <= w_tone_nxt;
      r_done  <= w_done_nxt;
`ifdef SEQ_GAP_EN
      r_gap   <= w_gap_nxt;
`endif
    end
  end

  assign oHALF_PERIOD = r_half;
  assign oTONE_EN     = r_tone;
  assign oNOTE_IDX    = r_idx;
  assign oBUSY        = (r_state != S_IDLE);
  assign oDONE        = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: a reference model expands the note table into
// the expected per-cycle output trace, directed and random tables are played
// and compared cycle by cycle.
module tb_melody_sequencer;
  localparam int DEPTH      = 4;
  localparam int IDX_W      = 2;
  localparam int PERIOD_W   = 21;
  localparam int DUR_W      = 4;
  localparam int TICK_DIV   = 10;
  localparam int GAP_CYCLES = 3;

  logic                iCLK = 1'b0;
  logic                iRST_N = 1'b0;
  logic                iWR_EN = 1'b0;
  logic [IDX_W-1:0]    iWR_ADDR = '0;
  logic [PERIOD_W-1:0] iWR_PERIOD = '0;
  logic [DUR_W-1:0]    iWR_DUR = '0;
  logic                iWR_LAST = 1'b0;
  logic                iSTART = 1'b0;
  logic                iSTOP = 1'b0;
  logic                iLOOP = 1'b0;
  logic [PERIOD_W-1:0] oHALF_PERIOD;
  logic                oTONE_EN;
  logic [IDX_W-1:0]    oNOTE_IDX;
  logic                oBUSY;
  logic                oDONE;

  melody_sequencer #(
    .DEPTH(DEPTH), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W),
    .TICK_DIV(TICK_DIV), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iWR_EN(iWR_EN), .iWR_ADDR(iWR_ADDR),
    .iWR_PERIOD(iWR_PERIOD), .iWR_DUR(iWR_DUR), .iWR_LAST(iWR_LAST),
    .iSTART(iSTART), .iSTOP(iSTOP), .iLOOP(iLOOP),
    .oHALF_PERIOD(oHALF_PERIOD), .oTONE_EN(oTONE_EN), .oNOTE_IDX(oNOTE_IDX),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  int n_chk  = 0;
  int n_pass = 0;

  // reference table
  int m_per [DEPTH];
  int m_dur [DEPTH];
  bit m_last[DEPTH];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [63:0] pk(input logic busy, input logic tone, input logic done,
                                     input logic [31:0] idx, input logic [31:0] half);
    return (64'(done) << 42) | (64'(tone) << 41) | (64'(busy) << 40) |
           (64'(idx) << 32) | 64'(half);
  endfunction

  function automatic logic [63:0] obs();
    return pk(oBUSY, oTONE_EN, oDONE, 32'(oNOTE_IDX), 32'(oHALF_PERIOD));
  endfunction

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic wr(input int a, input int p, input int d, input bit l, input bit upd);
    iWR_EN = 1'b1; iWR_ADDR = IDX_W'(a); iWR_PERIOD = PERIOD_W'(p);
    iWR_DUR = DUR_W'(d); iWR_LAST = l;
    step();
    iWR_EN = 1'b0;
    if (upd) begin m_per[a] = p; m_dur[a] = d; m_last[a] = l; end
  endtask

  // Play the model table. stop_at/start_at of -2 pick a random cycle,
  // -1 disables. wr_at injects a write to entry 0 while busy (must be ignored).
  // co_wr writes entry 0 in the same cycle as the start pulse.
  task automatic run(input bit loop, input int loops, input int stop_at, input int wr_at,
                     input int start_at, input bit co_wr, input int co_p);
    logic [63:0] q[$];
    int k, nk, pass, eff;
    if (co_wr) m_per[0] = co_p;
    k = 0; pass = 0;
    forever begin
      eff = (m_dur[k] == 0) ? 1 : m_dur[k];
      repeat (eff * TICK_DIV) q.push_back(pk(1, m_per[k] != 0, 0, k, m_per[k]));
      if (m_last[k] || k == DEPTH-1) begin
        pass++;
        nk = 0;
        if (!loop || pass == loops) break;
      end else nk = k + 1;
`ifdef SEQ_GAP_EN
      repeat (GAP_CYCLES) q.push_back(pk(1, 0, 0, nk, 0));
`endif
      k = nk;
    end
    if (loop) begin
`ifdef SEQ_GAP_EN
      repeat (GAP_CYCLES) q.push_back(pk(1, 0, 0, 0, 0));
`endif
      q.push_back(pk(1, m_per[0] != 0, 0, 0, m_per[0]));
      if (stop_at == -1) stop_at = q.size() - 1;
    end
    if (stop_at == -2) stop_at = $urandom_range(0, q.size() - 1);
    if (start_at == -2) start_at = $urandom_range(0, q.size() - 2);

    iLOOP = loop;
    iSTART = 1'b1;
    if (co_wr) begin
      iWR_EN = 1'b1; iWR_ADDR = '0; iWR_PERIOD = PERIOD_W'(co_p);
      iWR_DUR = DUR_W'(m_dur[0]); iWR_LAST = m_last[0];
    end
    step();
    iSTART = 1'b0; iWR_EN = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      chk("play", obs(), q[i]);
      if (i == stop_at) begin
        iSTOP = 1'b1; iSTART = 1'b1; iWR_EN = 1'b0;
        step();
        iSTOP = 1'b0; iSTART = 1'b0;
        chk("stop", obs(), 64'd0);
        step();
        chk("stop_idle", obs(), 64'd0);
        return;
      end
      iSTART = (i == start_at);
      iWR_EN = (i == wr_at);
      if (i == wr_at) begin
        iWR_ADDR = '0; iWR_PERIOD = PERIOD_W'(100); iWR_DUR = 1; iWR_LAST = 1'b1;
      end
      step();
    end
    iSTART = 1'b0; iWR_EN = 1'b0;
    chk("done_pulse", obs(), pk(0, 0, 1, 0, 0));
    step();
    chk("after_done", obs(), 64'd0);
  endtask

  initial begin
    #1;
    chk("reset", obs(), 64'd0);
    repeat (2) @(posedge iCLK);
    #3 iRST_N = 1'b1;
    step();
    chk("idle_after_reset", obs(), 64'd0);

    // basic melody: 31888 x2, rest x1, 37919 x1 last
    wr(0, 31888, 2, 0, 1);
    wr(1, 0, 1, 0, 1);
    wr(2, 37919, 1, 1, 1);
    run(0, 1, -1, -1, -1, 0, 0);
    // looping, three passes then stop right after the wrap
    run(1, 3, -1, -1, -1, 0, 0);
    // stop with start in the same cycle, mid entry 1
    run(0, 1, 25, -1, -1, 0, 0);
    // write while busy plus start while busy, both ignored
    run(0, 1, -1, 5, 12, 0, 0);
    run(0, 1, -1, -1, -1, 0, 0);
    // duration 0 plays as one time unit
    wr(1, 0, 0, 0, 1);
    run(0, 1, -1, -1, -1, 0, 0);
    // write to entry 0 in the start cycle is played
    run(0, 1, -1, -1, -1, 1, 12345);
    wr(0, 31888, 2, 0, 1);

    // asynchronous reset during play
    iSTART = 1'b1; step(); iSTART = 1'b0;
    repeat (5) step();
    chk("pre_rst", obs(), pk(1, 1, 0, 0, 31888));
    #2 iRST_N = 1'b0;
    #1 chk("async_rst", obs(), 64'd0);
    #2 iRST_N = 1'b1;
    repeat (3) step();
    chk("idle_post_rst", obs(), 64'd0);
    run(0, 1, -1, -1, -1, 0, 0);

    // two same-pitch entries (gap between them when enabled)
    wr(0, 500, 1, 0, 1);
    wr(1, 500, 1, 1, 1);
    run(0, 1, -1, -1, -1, 0, 0);
    run(1, 2, -1, -1, -1, 0, 0);

    // implicit last at index DEPTH-1
    wr(0, 7, 1, 0, 1); wr(1, 8, 0, 0, 1); wr(2, 0, 1, 0, 1); wr(3, 9, 1, 0, 1);
    run(0, 1, -1, -1, -1, 0, 0);

    // random tables
    for (int it = 0; it < 24; it++) begin
      bit lp;
      for (int a = 0; a < DEPTH; a++)
        wr(a, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2097151)),
           $urandom_range(0, 3), $urandom_range(0, 3) == 0, 1);
      lp = $urandom_range(0, 1);
      run(lp, $urandom_range(1, 2), ($urandom_range(0, 2) == 0) ? -2 : -1,
          -1, -2, $urandom_range(0, 3) == 0, $urandom_range(0, 2097151));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
